// File: rtl/aa_pkg.sv
// Shared types and constants for the antialias granule gather path.
package aa_pkg;

  localparam int unsigned AA_DW        = 32;
  localparam int unsigned N_SAMPLES    = 576;
  localparam int unsigned N_PAIRS      = 288;
  localparam int unsigned N_SB         = 32;
  localparam int unsigned LINES_PER_SB = 18;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } gather_state_t;

  typedef struct packed {
    logic [AA_DW-1:0] ch1;
    logic [AA_DW-1:0] ch2;
  } stereo_sample_t;

  typedef struct packed {
    logic [4:0] sb;
    logic [4:0] line;
    logic       sb_last;
  } gather_idx_t;

  typedef struct packed {
    stereo_sample_t s;
    gather_idx_t    idx;
  } gather_beat_t;

endpackage

// File: rtl/aa_gather_fifo.sv
// Small synchronous skid FIFO with occupancy count and synchronous flush.
module aa_gather_fifo #(
  parameter int unsigned WIDTH = 75,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// True dual-port read-first block RAM; optional output register (HIGH_PERFORMANCE).
// Writes from both ports are modelled on clka; in this design both ports share one clock.
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int unsigned RAM_WIDTH       = 64,
  parameter int unsigned RAM_DEPTH       = 576,
  parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                         clka,
  input  logic                         clkb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic [RAM_WIDTH-1:0]         dinb,
  input  logic                         wea,
  input  logic                         web,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         rsta,
  input  logic                         rstb,
  input  logic                         regcea,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         douta,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;
  logic [RAM_WIDTH-1:0] ram_data_b;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) ram[addra] <= dina;
      ram_data_a <= ram[addra];
    end
    if (enb && web) ram[addrb] <= dinb;
  end

  always_ff @(posedge clkb) begin
    if (enb) ram_data_b <= ram[addrb];
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_reg
    assign douta = ram_data_a;
    assign doutb = ram_data_b;
  end else begin : g_reg
    always_ff @(posedge clka) begin
      if (rsta)        douta <= '0;
      else if (regcea) douta <= ram_data_a;
    end
    always_ff @(posedge clkb) begin
      if (rstb)        doutb <= '0;
      else if (regceb) doutb <= ram_data_b;
    end
  end

endmodule

// File: rtl/aa_granule_gather.sv
// Gathers out-of-order antialias pairs into BRAM, then streams the granule subband-major.
// Optional duplicate/coverage check enabled by defining AA_GATHER_DUPCHK_EN.
module aa_granule_gather
  import aa_pkg::*;
#(
  parameter int unsigned DW         = AA_DW,
  parameter int unsigned RAM_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_frame_start,
  input  logic          in_v,
  input  logic [DW-1:0] ch1_in_x,
  input  logic [DW-1:0] ch1_in_y,
  input  logic [DW-1:0] ch2_in_x,
  input  logic [DW-1:0] ch2_in_y,
  input  logic [9:0]    is_pos_x,
  input  logic [9:0]    is_pos_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ch1_out,
  output logic [DW-1:0] ch2_out,
  output logic [4:0]    out_sb,
  output logic [4:0]    out_line,
  output logic          out_sb_last,
  output logic          gr_done,
  output logic          err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  gather_state_t      state, state_nxt;
  logic               restart, beat, x_ok, y_ok, last_beat;
  logic               wea, web, issue, pop, head_last, fifo_empty;
  logic [8:0]         pair_cnt;
  logic [4:0]         rd_sb, rd_line;
  logic [9:0]         rd_addr, addra;
  logic               rd_done;
  logic [RAM_LAT-1:0] pipe_v;
  gather_idx_t        pipe_idx [RAM_LAT];
  logic [CW-1:0]      inflight, fifo_count;
  logic [2*DW-1:0]    douta, doutb_unused;
  gather_beat_t       fifo_din, head;

  assign restart   = rst || new_frame_start;
  assign beat      = (state == COLLECT) && in_v && !restart;
  assign x_ok      = is_pos_x < 10'(N_SAMPLES);
  assign y_ok      = is_pos_y < 10'(N_SAMPLES);
  assign last_beat = beat && (pair_cnt == 9'(N_PAIRS - 1));
  assign wea       = beat && x_ok;
  assign web       = beat && y_ok && (is_pos_y != is_pos_x);

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RAM_LAT; i++) inflight += CW'(pipe_v[i]);
  end

  assign issue = (state == DRAIN) && !rd_done && !restart &&
                 (({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH));
  assign addra = (state == DRAIN) ? rd_addr : is_pos_x;

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH      (2 * DW),
    .RAM_DEPTH      (N_SAMPLES),
    .RAM_PERFORMANCE((RAM_LAT == 1) ? "LOW_LATENCY" : "HIGH_PERFORMANCE")
  ) u_ram (
    .clka  (clk),
    .clkb  (clk),
    .addra (addra),
    .addrb (is_pos_y),
    .dina  ({ch1_in_x, ch2_in_x}),
    .dinb  ({ch1_in_y, ch2_in_y}),
    .wea   (wea),
    .web   (web),
    .ena   (wea || issue),
    .enb   (web),
    .rsta  (rst),
    .rstb  (rst),
    .regcea(1'b1),
    .regceb(1'b1),
    .douta (douta),
    .doutb (doutb_unused)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (pop && head_last) state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart) state <= COLLECT;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (restart)   pair_cnt <= '0;
    else if (beat) pair_cnt <= pair_cnt + 9'd1;
  end

  // sb/line/addr walk together so the address needs no sb*18 multiply
  always_ff @(posedge clk) begin
    if (restart) begin
      rd_sb   <= '0;
      rd_line <= '0;
      rd_addr <= '0;
      rd_done <= 1'b0;
    end else if (issue) begin
      rd_addr <= rd_addr + 10'd1;
      if (rd_line == 5'(LINES_PER_SB - 1)) begin
        rd_line <= '0;
        rd_sb   <= rd_sb + 5'd1;
      end else begin
        rd_line <= rd_line + 5'd1;
      end
      if (rd_addr == 10'(N_SAMPLES - 1)) rd_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (restart) pipe_v <= '0;
    else begin
      pipe_v[0] <= issue;
      for (int unsigned i = 1; i < RAM_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_idx[0] <= '{sb: rd_sb, line: rd_line, sb_last: (rd_line == 5'(LINES_PER_SB - 1))};
    for (int unsigned i = 1; i < RAM_LAT; i++) pipe_idx[i] <= pipe_idx[i-1];
  end

  assign fifo_din = '{s: stereo_sample_t'(douta), idx: pipe_idx[RAM_LAT-1]};

  aa_gather_fifo #(
    .WIDTH($bits(gather_beat_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(new_frame_start),
    .push (pipe_v[RAM_LAT-1]),
    .din  (fifo_din),
    .pop  (pop),
    .dout (head),
    .count(fifo_count),
    .empty(fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign head_last   = (head.idx.sb == 5'(N_SB - 1)) && head.idx.sb_last;
  assign ch1_out     = out_valid ? head.s.ch1    : '0;
  assign ch2_out     = out_valid ? head.s.ch2    : '0;
  assign out_sb      = out_valid ? head.idx.sb   : '0;
  assign out_line    = out_valid ? head.idx.line : '0;
  assign out_sb_last = out_valid && head.idx.sb_last;

  always_ff @(posedge clk) begin
    if (restart) gr_done <= 1'b0;
    else         gr_done <= (state == DRAIN) && pop && head_last;
  end

`ifdef AA_GATHER_DUPCHK_EN
  logic [N_SAMPLES-1:0] written, written_nxt;
  logic                 err_hit, err_q;

  // x is marked before y is tested, so x==y is caught as a repeat
  always_comb begin
    written_nxt = written;
    err_hit     = 1'b0;
    if (beat) begin
      if (x_ok) begin
        if (written[is_pos_x]) err_hit = 1'b1;
        written_nxt[is_pos_x] = 1'b1;
      end else begin
        err_hit = 1'b1;
      end
      if (y_ok) begin
        if (written_nxt[is_pos_y]) err_hit = 1'b1;
        written_nxt[is_pos_y] = 1'b1;
      end else begin
        err_hit = 1'b1;
      end
      if (last_beat && !(&written_nxt)) err_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      written <= '0;
      err_q   <= 1'b0;
    end else begin
      written <= written_nxt;
      if (err_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
